// File: rtl/ram_latency_bridge_if.sv
// Ram_if: client-to-memory request bundle for ram_latency_bridge.
// The client drives en/we/addr/be/data_w; the memory side returns
// data_r together with a delay flag that stalls the client while a read
// is still in flight.
interface Ram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTE_COUNT = DATA_WIDTH / 8;

    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BYTE_COUNT-1:0] be;
    logic [DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  delay;

    // Requesting side (the core).
    modport master (
        output en, we, addr, be, data_w,
        input  data_r, delay
    );

    // Responding side; memory is the name the bridge uses for it.
    modport slave (
        input  en, we, addr, be, data_w,
        output data_r, delay
    );

    modport memory (
        input  en, we, addr, be, data_w,
        output data_r, delay
    );
endinterface

// File: rtl/ram_latency_bridge.sv
// ram_latency_bridge: adapts a single-cycle style client port to an SRAM
// whose read data arrives LATENCY cycles after the strobe. Writes pass
// straight through in IDLE; reads either complete next cycle (LATENCY=1)
// or park the FSM in WAIT with delay raised until the data is captured.
// Read data is captured on the LATENCY-th clock edge counted from the
// start of the strobe cycle, so it is visible to the client in cycle
// t+LATENCY. Client protocol violations in WAIT are ignored but latched
// into a sticky protocol_err flag.
module ram_latency_bridge #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int LATENCY    = 2,
    localparam int BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    Ram_if.memory                 core,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BYTE_COUNT-1:0] sram_be,
    output logic [DATA_WIDTH-1:0] sram_data_w,
    input  logic [DATA_WIDTH-1:0] sram_data_r,
    output logic                  protocol_err
);

    // Reject unsupported latencies at elaboration; cnt is only 3 bits wide.
    if (LATENCY < 1 || LATENCY > 7) begin : gBadLatency
        $fatal(1, "ram_latency_bridge: LATENCY must be within 1..7");
    end

    localparam bit         SINGLE_CYCLE = (LATENCY == 1);
    localparam logic [2:0] WAIT_LOAD    = 3'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] reqAddr_q;
    logic [DATA_WIDTH-1:0] dataR_q;
    logic                  delay_q;
    logic                  protocolErr_q;

    logic                  isIdle;
    logic                  violation;

    // The client path is only open in IDLE and is forced shut during reset.
    assign isIdle      = (state_q == IDLE);
    assign sram_en     = isIdle && core.en && !reset;
    assign sram_we     = isIdle && core.en && core.we && !reset;
    assign sram_addr   = core.addr;
    assign sram_be     = core.be;
    assign sram_data_w = core.data_w;

    // In WAIT the client must keep the same read request asserted.
    assign violation = (state_q == WAIT) &&
                       (!core.en || core.we || (core.addr != reqAddr_q));

    // Client-facing results are all straight from registers.
    assign core.data_r  = dataR_q;
    assign core.delay   = delay_q;
    assign protocol_err = protocolErr_q;

    // Request FSM: accepts reads in IDLE, counts down the SRAM latency in
    // WAIT and captures returned data into the hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            reqAddr_q     <= '0;
            dataR_q       <= '0;
            delay_q       <= 1'b0;
            protocolErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    delay_q <= 1'b0;
                    if (core.en && !core.we) begin
                        reqAddr_q <= core.addr;
                        if (SINGLE_CYCLE) begin
                            dataR_q <= sram_data_r;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                            delay_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (violation) begin
                        protocolErr_q <= 1'b1;
                    end
                    if (cnt_q == 3'd1) begin
                        dataR_q <= sram_data_r;
                        delay_q <= 1'b0;
                        cnt_q   <= 3'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                    delay_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_latency_bridge.sv
// tb_ram_latency_bridge: drives four bridge instances (LATENCY 1..4), each
// wired to its own pipelined SRAM model sharing one word array. Single
// cycle reads/writes are table driven; the multi-cycle cases are written
// out by hand.
module tb_ram_latency_bridge;

    logic clk = 1'b0;

    // 10 time-unit clock.
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [4:1]            en, we, rst;
    logic [4:1][31:0]      addr, dataW;
    logic [4:1][3:0]       be;
    logic [4:1]            sramEn, sramWe, delay, protErr;
    logic [4:1][31:0]      dataR, sramAddr, sramDataW, sramDataR;
    logic [4:1][3:0]       sramBe;

    // One bridge plus interface per latency value.
    for (genvar g = 1; g <= 4; g++) begin : gLat
        Ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        assign bus.en     = en[g];
        assign bus.we     = we[g];
        assign bus.addr   = addr[g];
        assign bus.be     = be[g];
        assign bus.data_w = dataW[g];
        assign dataR[g]   = bus.data_r;
        assign delay[g]   = bus.delay;

        ram_latency_bridge #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .LATENCY   (g)
        ) dut (
            .clk         (clk),
            .reset       (rst[g]),
            .core        (bus.memory),
            .sram_en     (sramEn[g]),
            .sram_we     (sramWe[g]),
            .sram_addr   (sramAddr[g]),
            .sram_be     (sramBe[g]),
            .sram_data_w (sramDataW[g]),
            .sram_data_r (sramDataR[g]),
            .protocol_err(protErr[g])
        );
    end

    // ---------------- SRAM model ----------------
    logic [31:0] memW [0:255];
    bit   [255:0] written;
    logic [31:0] pipe [1:4][0:6];
    int          strobes [1:4];

    function automatic logic [31:0] defaultWord(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    function automatic logic [31:0] readWord(input logic [7:0] a);
        return written[a] ? memW[a] : defaultWord(a);
    endfunction

    function automatic logic [31:0] mergeWord(input logic [7:0] a, input logic [31:0] d,
                                              input logic [3:0] b);
        logic [31:0] w;
        w = readWord(a);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        return w;
    endfunction

    // Latch read addresses on strobe, shift the latency pipeline, commit writes.
    always @(posedge clk) begin
        for (int k = 1; k <= 4; k++) begin
            if (sramEn[k]) strobes[k] <= strobes[k] + 1;
            if (sramEn[k] && !sramWe[k]) pipe[k][0] <= sramAddr[k];
            for (int j = 1; j < 7; j++) pipe[k][j] <= pipe[k][j-1];
            if (sramEn[k] && sramWe[k]) begin
                memW[sramAddr[k][7:0]]    <= mergeWord(sramAddr[k][7:0], sramDataW[k], sramBe[k]);
                written[sramAddr[k][7:0]] <= 1'b1;
            end
        end
    end

    // Instance k sees read data for its strobe during cycle t+k-1.
    always_comb begin
        sramDataR    = '0;
        sramDataR[1] = readWord(sramAddr[1][7:0]);
        for (int k = 2; k <= 4; k++) sramDataR[k] = readWord(pipe[k][k-2][7:0]);
    end

    // ---------------- Helpers ----------------
    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] dataW;
        logic        expSramEn;
        logic        expSramWe;
        logic [31:0] expDataR;
    } vec_t;

    vec_t vecs [13];
    logic [0:5] b2bDelay = 6'b110110;
    int base;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic e, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d);
        en[k]    = e;
        we[k]    = w;
        addr[k]  = a;
        be[k]    = b;
        dataW[k] = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    task automatic resetDut(input int k);
        rst[k] = 1'b1;
        applyStimulus(k, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
        #1;
        checkOutput($sformatf("L%0d sram_en in reset", k), 32'(sramEn[k]), 32'd0);
        checkOutput($sformatf("L%0d sram_we in reset", k), 32'(sramWe[k]), 32'd0);
        stepCycle();
        rst[k] = 1'b0;
        applyStimulus(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput($sformatf("L%0d delay after reset", k), 32'(delay[k]), 32'd0);
        checkOutput($sformatf("L%0d data_r after reset", k), dataR[k], 32'd0);
        checkOutput($sformatf("L%0d protocol_err after reset", k), 32'(protErr[k]), 32'd0);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- Main sequence ----------------
    initial begin
        en    = '0;
        we    = '0;
        rst   = '1;
        addr  = '0;
        be    = '0;
        dataW = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'h03, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE03};
        vecs[1]  = '{1'b1, 1'b0, 32'h07, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE07};
        vecs[2]  = '{1'b1, 1'b0, 32'h11, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE11};
        vecs[3]  = '{1'b1, 1'b0, 32'h40, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE40};
        vecs[4]  = '{1'b1, 1'b0, 32'h80, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE80};
        vecs[5]  = '{1'b1, 1'b0, 32'hFF, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEEFF};
        vecs[6]  = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b0, 32'h02, 4'hF, 32'h0,        1'b1, 1'b0, 32'hC0FFEE02};
        vecs[8]  = '{1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678, 1'b1, 1'b1, 32'hC0FFEE02};
        vecs[9]  = '{1'b0, 1'b1, 32'h30, 4'hF, 32'h0,        1'b0, 1'b0, 32'hC0FFEE02};
        vecs[10] = '{1'b1, 1'b0, 32'h30, 4'hF, 32'h0,        1'b1, 1'b0, 32'h12345678};
        vecs[11] = '{1'b1, 1'b1, 32'h30, 4'h8, 32'hAB000000, 1'b1, 1'b1, 32'h12345678};
        vecs[12] = '{1'b1, 1'b0, 32'h30, 4'hF, 32'h0,        1'b1, 1'b0, 32'hAB345678};

        for (int k = 1; k <= 4; k++) resetDut(k);

        // LATENCY=1: back-to-back reads and pass-through writes, never delayed.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].dataW);
            #1;
            checkOutput($sformatf("L1 vec%0d sram_en", i), 32'(sramEn[1]), 32'(vecs[i].expSramEn));
            checkOutput($sformatf("L1 vec%0d sram_we", i), 32'(sramWe[1]), 32'(vecs[i].expSramWe));
            checkOutput($sformatf("L1 vec%0d sram_addr", i), sramAddr[1], vecs[i].addr);
            stepCycle();
            checkOutput($sformatf("L1 vec%0d data_r", i), dataR[1], vecs[i].expDataR);
            checkOutput($sformatf("L1 vec%0d delay", i), 32'(delay[1]), 32'd0);
        end
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // LATENCY=2: single read of 0x10.
        base = strobes[2];
        applyStimulus(2, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        #1;
        checkOutput("L2 read strobe", 32'(sramEn[2]), 32'd1);
        checkOutput("L2 read we", 32'(sramWe[2]), 32'd0);
        checkOutput("L2 read addr", sramAddr[2], 32'h10);
        stepCycle();
        checkOutput("L2 delay t+1", 32'(delay[2]), 32'd1);
        checkOutput("L2 no strobe in WAIT", 32'(sramEn[2]), 32'd0);
        stepCycle();
        checkOutput("L2 delay t+2", 32'(delay[2]), 32'd0);
        checkOutput("L2 data t+2", dataR[2], 32'hDEADBEEF);
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("L2 strobe count", 32'(strobes[2] - base), 32'd1);

        // LATENCY=2: partial write to 0x20, then read it back.
        applyStimulus(2, 1'b1, 1'b1, 32'h20, 4'b0011, 32'hA5A5A5A5);
        #1;
        checkOutput("L2 write sram_en", 32'(sramEn[2]), 32'd1);
        checkOutput("L2 write sram_we", 32'(sramWe[2]), 32'd1);
        checkOutput("L2 write sram_be", 32'(sramBe[2]), 32'h3);
        checkOutput("L2 write sram_data_w", sramDataW[2], 32'hA5A5A5A5);
        stepCycle();
        checkOutput("L2 write delay", 32'(delay[2]), 32'd0);
        checkOutput("L2 data held over write", dataR[2], 32'hDEADBEEF);
        applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        checkOutput("L2 readback strobe", 32'(sramEn[2]), 32'd1);
        stepCycle();
        checkOutput("L2 readback delay t+1", 32'(delay[2]), 32'd1);
        checkOutput("L2 readback data held t+1", dataR[2], 32'hDEADBEEF);
        stepCycle();
        checkOutput("L2 readback delay t+2", 32'(delay[2]), 32'd0);
        checkOutput("L2 readback data", dataR[2], 32'hC0FFA5A5);
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // LATENCY=3: second read issued in the cycle the first one returns.
        base = strobes[3];
        applyStimulus(3, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            stepCycle();
            checkOutput($sformatf("L3 b2b delay t+%0d", i), 32'(delay[3]), 32'(b2bDelay[i-1]));
            if (i == 3) begin
                checkOutput("L3 b2b first data", dataR[3], 32'hC0FFEE04);
                applyStimulus(3, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
                #1;
                checkOutput("L3 b2b second strobe", 32'(sramEn[3]), 32'd1);
            end
            if (i == 6) begin
                checkOutput("L3 b2b second data", dataR[3], 32'hC0FFEE08);
                applyStimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            end
        end
        stepCycle();
        checkOutput("L3 b2b strobe count", 32'(strobes[3] - base), 32'd2);
        checkOutput("L3 b2b no protocol_err", 32'(protErr[3]), 32'd0);

        // LATENCY=3: address changes during WAIT.
        base = strobes[3];
        applyStimulus(3, 1'b1, 1'b0, 32'h50, 4'hF, 32'h0);
        stepCycle();
        applyStimulus(3, 1'b1, 1'b0, 32'h51, 4'hF, 32'h0);
        #1;
        checkOutput("L3 bad addr no strobe", 32'(sramEn[3]), 32'd0);
        checkOutput("L3 protocol_err before", 32'(protErr[3]), 32'd0);
        stepCycle();
        checkOutput("L3 protocol_err rises", 32'(protErr[3]), 32'd1);
        checkOutput("L3 bad addr delay t+2", 32'(delay[3]), 32'd1);
        applyStimulus(3, 1'b1, 1'b0, 32'h50, 4'hF, 32'h0);
        stepCycle();
        checkOutput("L3 bad addr delay t+3", 32'(delay[3]), 32'd0);
        checkOutput("L3 bad addr original data", dataR[3], 32'hC0FFEE50);
        checkOutput("L3 protocol_err sticky", 32'(protErr[3]), 32'd1);
        applyStimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("L3 bad addr strobe count", 32'(strobes[3] - base), 32'd1);
        checkOutput("L3 protocol_err still set", 32'(protErr[3]), 32'd1);

        // LATENCY=3: write presented during WAIT is dropped.
        applyStimulus(3, 1'b1, 1'b0, 32'h60, 4'hF, 32'h0);
        stepCycle();
        applyStimulus(3, 1'b1, 1'b1, 32'h60, 4'hF, 32'h11111111);
        #1;
        checkOutput("L3 WAIT write sram_we", 32'(sramWe[3]), 32'd0);
        checkOutput("L3 WAIT write sram_en", 32'(sramEn[3]), 32'd0);
        stepCycle();
        applyStimulus(3, 1'b1, 1'b0, 32'h60, 4'hF, 32'h0);
        stepCycle();
        checkOutput("L3 WAIT write dropped", dataR[3], 32'hC0FFEE60);
        applyStimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        resetDut(3);

        // LATENCY=4: reset at t+2 aborts the read.
        applyStimulus(4, 1'b1, 1'b0, 32'h70, 4'hF, 32'h0);
        stepCycle();
        checkOutput("L4 delay t+1", 32'(delay[4]), 32'd1);
        stepCycle();
        rst[4] = 1'b1;
        applyStimulus(4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stepCycle();
        rst[4] = 1'b0;
        checkOutput("L4 delay after abort", 32'(delay[4]), 32'd0);
        checkOutput("L4 data after abort", dataR[4], 32'd0);
        for (int i = 4; i <= 5; i++) begin
            stepCycle();
            checkOutput($sformatf("L4 late data ignored t+%0d", i), dataR[4], 32'd0);
            checkOutput($sformatf("L4 idle delay t+%0d", i), 32'(delay[4]), 32'd0);
        end
        applyStimulus(4, 1'b1, 1'b0, 32'h71, 4'hF, 32'h0);
        #1;
        checkOutput("L4 accepts read after abort", 32'(sramEn[4]), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            stepCycle();
            checkOutput($sformatf("L4 delay s+%0d", i), 32'(delay[4]), 32'd1);
        end
        stepCycle();
        checkOutput("L4 delay s+4", 32'(delay[4]), 32'd0);
        checkOutput("L4 data s+4", dataR[4], 32'hC0FFEE71);
        applyStimulus(4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ram_latency_bridge.md
RAM_LATENCY_BRIDGE -- requirements
Module: ram_latency_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address bits on both sides.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bits per word; BYTE_COUNT = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter LATENCY, default 2, legal range 1..7, giving the backing SRAM read latency in cycles.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  the single clock for the core and SRAM sides.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 core  Ram_if.memory  ADDR_WIDTH/DATA_WIDTH  client access; en, addr, data_w, we and be are inputs, data_r and delay are outputs.
REQ-008 sram_en  output  1  SRAM access strobe.
REQ-009 sram_we  output  1  SRAM write strobe.
REQ-010 sram_addr  output  ADDR_WIDTH  SRAM word address.
REQ-011 sram_be  output  BYTE_COUNT  SRAM byte enables.
REQ-012 sram_data_w  output  DATA_WIDTH  SRAM write data.
REQ-013 sram_data_r  input  DATA_WIDTH  SRAM read data, valid LATENCY cycles after a read strobe.
REQ-014 protocol_err  output  1  sticky flag for a client protocol violation.

Function
REQ-015 The FSM SHALL have states IDLE and WAIT, plus a 3-bit countdown counter cnt.
REQ-016 IDLE accepts a request when core.en=1. A write (we=1) SHALL be forwarded combinationally to the SRAM in the same cycle: sram_en=1, sram_we=1, with addr, be and data_w passed through. The write completes in that cycle, core.delay stays 0, and the FSM stays in IDLE.
REQ-017 An IDLE read (en=1, we=0) SHALL drive sram_en=1 and sram_we=0 with addr combinationally in cycle t, and capture addr into a request register.
REQ-018 For LATENCY=1, core.data_r SHALL equal the SRAM data at t+1 with delay=0, and the FSM stays in IDLE.
REQ-019 For LATENCY>1, after the read at t the FSM SHALL enter WAIT with cnt=LATENCY-1.
REQ-020 In WAIT, core.delay SHALL be 1 in cycles t+1..t+LATENCY-1, cnt SHALL decrement each cycle, and sram_en SHALL be 0.
REQ-021 At cycle t+LATENCY, sram_data_r SHALL be registered into data_r, delay SHALL be 0, and the FSM returns to IDLE.
REQ-022 core.data_r SHALL be a registered hold value; it changes only when read data returns and is otherwise stable, including across writes.
REQ-023 A new request presented in the same cycle that read data returns (delay=0) SHALL be accepted as in IDLE, giving back-to-back reads with no bubble beyond LATENCY.
REQ-024 In WAIT, the client is required to hold en=1, we=0 and addr constant. Any of the following in WAIT SHALL set protocol_err=1 until reset:
  - en=0
  - we=1
  - addr differing from the captured address
REQ-025 A violating input in WAIT SHALL be ignored: no SRAM strobe is issued, the outstanding read still completes on schedule, and a write presented in WAIT is dropped.
REQ-026 The combinational path from core inputs to sram_* outputs SHALL be active only in IDLE; in WAIT, sram_en=0 and sram_we=0.
REQ-027 delay SHALL be a registered output with no combinational path from core.en.
REQ-028 Out-of-range LATENCY (0 or greater than 7) SHALL be a fatal elaboration error.

Reset
REQ-029 On reset=1 at a clock edge the block SHALL set: FSM=IDLE, cnt=0, data_r=0, delay=0, protocol_err=0.
REQ-030 While reset=1, sram_en and sram_we SHALL be 0 regardless of core inputs.
REQ-031 Reset during WAIT SHALL abort the outstanding read: SRAM data returning later is discarded, and the first cycle after reset is IDLE with delay=0.

Verification
REQ-032 LATENCY=2: read addr 0x10 (SRAM holds 0xDEADBEEF) at t -> delay=1 at t+1; data_r=0xDEADBEEF with delay=0 at t+2; one SRAM strobe total.
REQ-033 LATENCY=3: reads to 0x4 then 0x8 with the second presented the cycle data returns -> delay pattern 1,1,0,1,1,0; data returned in order; exactly 2 SRAM strobes.
REQ-034 Write 0xA5A5A5A5 to 0x20 with be=4'b0011, then read 0x20 -> sram_be=4'b0011 during the write cycle; the write causes no delay; data_r stays at its prior value until the read returns.
REQ-035 LATENCY=3: client changes addr during WAIT -> protocol_err rises the next cycle and stays 1; the original read's data is still returned at t+3; no extra SRAM strobe.
REQ-036 LATENCY=4: reset asserted at t+2 of a read -> cycle after reset shows delay=0, data_r=0, FSM IDLE; late SRAM data does not update data_r.
REQ-037 LATENCY=1: 8 consecutive reads -> delay is never 1; each data_r matches the SRAM model one cycle after its request.
